rgb_seq_pwm: RTL and testbench
==============================

// Module: rgb_seq_pwm
// PURPOSE
//   Parametrised N-channel LED colour sequencer with per-channel PWM. Successor to the fixed
//   1 s R/G/B stepper: adds crossfade and breathe modes, a run enable and generic width/count.
//   Sits between top-level control and the SB_RGBA_DRV RGBnPWM inputs; top wires pwm[i] to RGBiPWM.
// PARAMETERS
//   NCH        3         number of LED channels, >=2
//   PWM_BITS   8         PWM resolution; MAX = 2**PWM_BITS-1
//   TICK_DIV   12000     clk cycles per sequencer tick, >=2
//   HOLD_TICKS 1000      ticks a colour is held before advancing/fading, >=1
// PORTS
//   clk         in   1                  system clock (12 MHz on board)
//   rst_n       in   1                  synchronous reset, active low
//   en          in   1                  1 = sequencer runs; 0 = freeze prescaler/FSM, PWM keeps running
//   mode        in   2                  0 STEP, 1 FADE, 2 BREATHE, 3 reserved (= STEP)
//   pwm         out  NCH                registered PWM outputs, bit i = channel i
//   phase       out  $clog2(NCH)        index of currently held/leading channel
//   wrap        out  1                  1-cycle pulse when phase advances NCH-1 -> 0
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): prescaler, hold_cnt, level, phase, pwm_ctr, duty[*], pwm, wrap = 0;
//     state=HOLD; mode_q=mode. Reset mid-fade aborts immediately, no partial state kept.
//   Prescaler: counts 0..TICK_DIV-1 while en=1; tick=1 for the cycle it equals TICK_DIV-1, then 0.
//     en=0 holds prescaler and all FSM regs; tick never asserts.
//   Mode sampling: mode_q<=mode only on tick. If changed: state<=HOLD, hold_cnt<=0, level<=0,
//     phase kept; new mode acts from that tick on. Mode 3 behaves exactly as mode 0.
//   FSM states HOLD, FADE, UP, DOWN (all transitions on tick only):
//     STEP: HOLD only. hold_cnt++; at hold_cnt==HOLD_TICKS-1: hold_cnt<=0, phase<=next.
//       duty[phase]=MAX, others 0.
//     FADE: HOLD as STEP but goes to FADE (level<=0) instead of advancing phase.
//       FADE: level++ per tick; duty[phase]=MAX-level, duty[next]=level, others 0.
//       level==MAX on tick: phase<=next, level<=0, state<=HOLD.
//     BREATHE: UP: level++, at MAX -> DOWN; DOWN: level--, at 0 -> HOLD; HOLD counts
//       HOLD_TICKS then -> UP. All channels duty=level; phase frozen.
//   next = (phase==NCH-1) ? 0 : phase+1. wrap=1 for one cycle on the tick phase goes NCH-1 -> 0.
//   PWM: pwm_ctr free-running PWM_BITS, wraps MAX->0. Duty target computed combinationally from
//     FSM; duty_q latched only in the cycle pwm_ctr==MAX (glitch-free period boundary).
//     pwm[i] <= (pwm_ctr < duty_q[i]): duty 0 -> constantly 0; duty MAX -> high MAX of 2**PWM_BITS cycles.
//   Latency: FSM change -> visible duty_q at next pwm_ctr wrap -> pwm one further cycle.
//   level and hold_cnt never exceed MAX / HOLD_TICKS-1; no arithmetic overflow permitted.
//   Simultaneous tick and mode change: mode change wins (reset to HOLD), no phase advance that tick.
// TESTING (bench params NCH=3, PWM_BITS=3, TICK_DIV=4, HOLD_TICKS=2)
//   Reset: rst_n=0 3 cycles, en=1 -> pwm=000, phase=0, wrap=0 throughout and 1 cycle after release.
//   STEP: mode=0 en=1 -> phase 0,1,2,0 every 8 clks; pwm[phase] high 7 of 8 cycles; wrap pulse
//     exactly once per 24 clks, on the 2->0 advance.
//   FADE: mode=1 -> after 8-clk hold, duty pair (7-k,k) for k=0..7 each tick; phase 0->1 when k=7;
//     pwm[0]+pwm[1] high-count per PWM period sums to 7; pwm[2] stays 0.
//   BREATHE: mode=2 -> all three pwm identical; duty ramps 0..7..0 then 2-tick hold; phase constant.
//   en=0 mid-FADE at level 3 for 50 clks -> duties frozen at (4,3), pwm still toggling; en=1 resumes at 4.
//   Mode 1->0 on a tick mid-fade -> state HOLD, level 0, phase unchanged, duty[phase]=7 next period.

Source files
------------

// File: rtl/rgb_seq_pwm.sv
// N-channel LED colour sequencer (step / crossfade / breathe) with per-channel PWM outputs.
// Duty targets are latched only at the PWM period boundary, so every period stays glitch-free.

module rgb_seq_pwm #(
    parameter int NCH        = 3,
    parameter int PWM_BITS   = 8,
    parameter int TICK_DIV   = 12000,
    parameter int HOLD_TICKS = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [1:0]             mode,
    output logic [NCH-1:0]         pwm,
    output logic [$clog2(NCH)-1:0] phase,
    output logic                   wrap
);

    localparam int PW   = $clog2(NCH);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [HC_W-1:0]     HC_LAST = HC_W'(HOLD_TICKS - 1);
    localparam logic [PW-1:0]       PH_LAST = PW'(NCH - 1);

    localparam logic [1:0] M_FADE    = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_FADE = 2'd1,
        S_UP   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic   [PS_W-1:0]                 presc_q, presc_d;
    logic   [HC_W-1:0]                 hold_cnt_q, hold_cnt_d;
    logic   [PWM_BITS-1:0]             level_q, level_d;
    logic   [PW-1:0]                   phase_q, phase_d;
    logic   [1:0]                      mode_q, mode_d;
    logic                              wrap_q, wrap_d;
    logic   [PWM_BITS-1:0]             pwm_ctr_q;
    logic   [NCH-1:0][PWM_BITS-1:0]    duty_q;
    logic   [NCH-1:0][PWM_BITS-1:0]    duty_s;
    logic   [NCH-1:0]                  pwm_q;
    logic                              tick_s;
    logic   [PW-1:0]                   next_phase_s;

    assign tick_s       = en && (presc_q == PS_LAST);
    assign next_phase_s = (phase_q == PH_LAST) ? {PW{1'b0}} : phase_q + PW'(1);

    // Prescaler and sequencer next-state; a mode change on a tick overrides any advance.
    always_comb begin
        presc_d    = presc_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        phase_d    = phase_q;
        state_d    = state_q;
        mode_d     = mode_q;
        wrap_d     = 1'b0;

        if (en) begin
            presc_d = (presc_q == PS_LAST) ? {PS_W{1'b0}} : presc_q + PS_W'(1);
        end else begin
            presc_d = presc_q;
        end

        if (tick_s) begin
            mode_d = mode;
            if (mode != mode_q) begin
                state_d    = S_HOLD;
                hold_cnt_d = {HC_W{1'b0}};
                level_d    = {PWM_BITS{1'b0}};
            end else begin
                case (state_q)
                    S_FADE: begin
                        if (level_q == MAX) begin
                            phase_d = next_phase_s;
                            wrap_d  = (phase_q == PH_LAST);
                            level_d = {PWM_BITS{1'b0}};
                            state_d = S_HOLD;
                        end else begin
                            level_d = level_q + PWM_BITS'(1);
                        end
                    end
                    S_UP: begin
                        if (level_q == MAX) begin
                            state_d = S_DOWN;
                        end else begin
                            level_d = level_q + PWM_BITS'(1);
                        end
                    end
                    S_DOWN: begin
                        if (level_q == {PWM_BITS{1'b0}}) begin
                            state_d = S_HOLD;
                        end else begin
                            level_d = level_q - PWM_BITS'(1);
                        end
                    end
                    default: begin
                        if (hold_cnt_q == HC_LAST) begin
                            hold_cnt_d = {HC_W{1'b0}};
                            case (mode_q)
                                M_FADE: begin
                                    state_d = S_FADE;
                                    level_d = {PWM_BITS{1'b0}};
                                end
                                M_BREATHE: begin
                                    state_d = S_UP;
                                end
                                default: begin
                                    phase_d = next_phase_s;
                                    wrap_d  = (phase_q == PH_LAST);
                                end
                            endcase
                        end else begin
                            hold_cnt_d = hold_cnt_q + HC_W'(1);
                        end
                    end
                endcase
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // Duty target per channel; mode 3 falls through to the step pattern.
    always_comb begin
        duty_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mode_q == M_BREATHE) begin
                duty_s[i] = level_q;
            end else if ((mode_q == M_FADE) && (state_q == S_FADE)) begin
                if (phase_q == PW'(i)) begin
                    duty_s[i] = MAX - level_q;
                end else if (next_phase_s == PW'(i)) begin
                    duty_s[i] = level_q;
                end else begin
                    duty_s[i] = {PWM_BITS{1'b0}};
                end
            end else begin
                duty_s[i] = (phase_q == PW'(i)) ? MAX : {PWM_BITS{1'b0}};
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= {PS_W{1'b0}};
            hold_cnt_q <= {HC_W{1'b0}};
            level_q    <= {PWM_BITS{1'b0}};
            phase_q    <= {PW{1'b0}};
            state_q    <= S_HOLD;
            mode_q     <= mode;
            wrap_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            wrap_q     <= wrap_d;
        end
    end

    // PWM counter, period-boundary duty latch and registered comparators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_ctr_q <= {PWM_BITS{1'b0}};
            duty_q    <= '0;
            pwm_q     <= {NCH{1'b0}};
        end else begin
            pwm_ctr_q <= pwm_ctr_q + PWM_BITS'(1);
            if (pwm_ctr_q == MAX) begin
                duty_q <= duty_s;
            end else begin
                duty_q <= duty_q;
            end
            for (int i = 0; i < NCH; i++) begin
                pwm_q[i] <= (pwm_ctr_q < duty_q[i]);
            end
        end
    end

    assign pwm   = pwm_q;
    assign phase = phase_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_rgb_seq_pwm.sv
// Randomised bench for rgb_seq_pwm: a per-tick colour-program model predicts every output cycle,
// expectations are queued at each rising edge and a monitor compares them on the falling edge.

module tb_rgb_seq_pwm;

    localparam int NCH        = 3;
    localparam int PWM_BITS   = 3;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int MAXV       = 7;
    localparam int PW         = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [1:0]     mode;
    logic [NCH-1:0] pwm;
    logic [PW-1:0]  phase;
    logic           wrap;

    rgb_seq_pwm #(
        .NCH(NCH), .PWM_BITS(PWM_BITS), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .pwm(pwm), .phase(phase), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // One tick interval of the colour program: duties shown during it, phase advance at its end.
    typedef struct packed {
        logic [NCH-1:0][PWM_BITS-1:0] duty;
        logic                         adv;
    } entry_t;

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic [PW-1:0]  phase;
        logic           wrap;
    } obs_t;

    entry_t prog[$];
    obs_t   exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int                           m_phase, m_mode, m_presc, m_ctr;
    logic [NCH-1:0][PWM_BITS-1:0] m_duty;
    logic [NCH-1:0]               m_pwm;
    logic                         m_wrap;

    // Append one full repetition of the pattern for mode md starting at phase p.
    function automatic void build(input int p, input int md);
        entry_t e;
        int     mm;
        mm = (md == 3) ? 0 : md;
        for (int h = 0; h < HOLD_TICKS; h++) begin
            e.duty = '0;
            if (mm != 2) e.duty[p] = PWM_BITS'(MAXV);
            e.adv = (mm == 0) && (h == HOLD_TICKS - 1);
            prog.push_back(e);
        end
        if (mm == 1) begin
            for (int k = 0; k <= MAXV; k++) begin
                e.duty = '0;
                e.duty[p] = PWM_BITS'(MAXV - k);
                e.duty[(p + 1) % NCH] = PWM_BITS'(k);
                e.adv = (k == MAXV);
                prog.push_back(e);
            end
        end
        if (mm == 2) begin
            for (int k = 0; k <= MAXV; k++) begin
                for (int c = 0; c < NCH; c++) e.duty[c] = PWM_BITS'(k);
                e.adv = 1'b0;
                prog.push_back(e);
            end
            for (int k = MAXV; k >= 0; k--) begin
                for (int c = 0; c < NCH; c++) e.duty[c] = PWM_BITS'(k);
                e.adv = 1'b0;
                prog.push_back(e);
            end
        end
    endfunction

    // Reference model: predicts the outputs that follow each rising edge.
    initial begin
        obs_t o;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_mode  = int'(mode);
                m_presc = 0;
                m_ctr   = 0;
                m_duty  = '0;
                m_pwm   = '0;
                m_wrap  = 1'b0;
                prog.delete();
                build(0, m_mode);
            end else begin
                for (int i = 0; i < NCH; i++) m_pwm[i] = (m_ctr < int'(m_duty[i]));
                if (m_ctr == MAXV) m_duty = prog[0].duty;
                m_ctr  = (m_ctr + 1) % (MAXV + 1);
                m_wrap = 1'b0;
                if (en) begin
                    if (m_presc == TICK_DIV - 1) begin
                        if (int'(mode) != m_mode) begin
                            m_mode = int'(mode);
                            prog.delete();
                            build(m_phase, m_mode);
                        end else begin
                            if (prog[0].adv) begin
                                m_wrap  = (m_phase == NCH - 1);
                                m_phase = (m_phase + 1) % NCH;
                            end
                            void'(prog.pop_front());
                            if (prog.size() == 0) build(m_phase, m_mode);
                        end
                    end
                    m_presc = (m_presc + 1) % TICK_DIV;
                end
            end
            o.pwm   = m_pwm;
            o.phase = PW'(m_phase);
            o.wrap  = m_wrap;
            exp_q.push_back(o);
        end
    end

    // Monitor: every cycle the DUT presents an output word; pop and compare it.
    initial begin
        obs_t o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                n_cmp++;
                if ({pwm, phase, wrap} !== o) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got pwm=%b phase=%0d wrap=%b want pwm=%b phase=%0d wrap=%b",
                             $time, pwm, phase, wrap, o.pwm, o.phase, o.wrap);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stop just before a sequencer tick edge (optionally while mid-crossfade), bounded.
    task automatic wait_tick(input bit need_fade);
        int budget;
        bit hit;
        budget = 0;
        hit = (m_presc == TICK_DIV - 1) &&
              (!need_fade || (m_mode == 1 && prog.size() > 1 && prog.size() <= MAXV));
        while (!hit && budget < 300) begin
            run(1);
            budget++;
            hit = (m_presc == TICK_DIV - 1) &&
                  (!need_fade || (m_mode == 1 && prog.size() > 1 && prog.size() <= MAXV));
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL tick_align got budget=%0d want <300", budget);
        end
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd0;
        run(3);
        rst_n = 1'b1;
        run(80);

        mode = 2'd1;
        run(120);

        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(22);
        en = 1'b0;
        run(50);
        en = 1'b1;
        run(40);

        wait_tick(1'b1);
        mode = 2'd0;
        run(40);

        mode = 2'd2;
        run(120);
        mode = 2'd3;
        run(40);
        mode = 2'd1;
        run(60);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rst_n = 1'b0;
                run($urandom_range(1, 3));
                rst_n = 1'b1;
            end else if (r <= 3) begin
                en = 1'b1;
                wait_tick(1'b0);
            end
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 4) != 0);
            run($urandom_range(1, 40));
        end

        en = 1'b1;
        run(10);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
